// File: rtl/conv_3_sched.sv
// conv_3_sched: sequencer for the 3x3 FP16 convolution datapath.
// Loads the kernel, streams 3-wide image strips, tags results.
module conv_3_sched #(
  parameter  int DATA_WIDTH  = 16,
  parameter  int KERNEL_SIZE = 3,
  parameter  int IMG_W_MAX   = 64,
  parameter  int IMG_H_MAX   = 64,
  localparam int WD = $clog2(IMG_W_MAX) + 1,
  localparam int HD = $clog2(IMG_H_MAX) + 1,
  localparam int WA = $clog2(IMG_W_MAX),
  localparam int HA = $clog2(IMG_H_MAX),
  localparam int LW = KERNEL_SIZE * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WD-1:0]         img_w,
  input  logic [HD-1:0]         img_h,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  mem_rd_en,
  output logic                  mem_sel,
  output logic [HA-1:0]         mem_row,
  output logic [WA-1:0]         mem_col,
  input  logic [LW-1:0]         mem_rd_data,
  output logic [LW-1:0]         conv_data_in,
  output logic                  conv_kernel_load,
  output logic                  conv_valid_in,
  output logic                  conv_valid_out,
  input  logic [DATA_WIDTH-1:0] conv_result,
  output logic                  out_valid,
  output logic [HA-1:0]         out_row,
  output logic [WA-1:0]         out_col,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam logic [WD-1:0] W_MIN  = WD'(KERNEL_SIZE);
  localparam logic [WD-1:0] W_LIM  = WD'(IMG_W_MAX);
  localparam logic [HD-1:0] H_MIN  = HD'(KERNEL_SIZE);
  localparam logic [HD-1:0] H_LIM  = HD'(IMG_H_MAX);
  localparam logic [WD-1:0] W_NEXT = WD'(KERNEL_SIZE + 1);
  localparam logic [HA-1:0] K_ROW  = HA'(KERNEL_SIZE);
  localparam logic [HA-1:0] K_LAST = HA'(KERNEL_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_K,
    S_STREAM,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [WD-1:0] r_w;
  logic [HD-1:0] r_h;
  logic [HA-1:0] r_row;
  logic [WA-1:0] r_col;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic          r_rd_en;
  logic          r_sel;

  logic          r_vin;
  logic          r_kld;
  logic          r_zero;
  logic          r_p_tag;
  logic [HA-1:0] r_p_row;
  logic [WA-1:0] r_p_col;
  logic          r_t1_v;
  logic [HA-1:0] r_t1_row;
  logic [WA-1:0] r_t1_col;
  logic          r_t2_v;
  logic [HA-1:0] r_t2_row;
  logic [WA-1:0] r_t2_col;

  logic          w_dims_ok;
  logic          w_row_last;
  logic          w_more;
  logic          w_img_issue;
  logic          w_flush;
  logic          w_qual;
  logic [HA-1:0] w_tag_row;

  assign w_dims_ok = (img_w >= W_MIN) && (img_w <= W_LIM) &&
                     (img_h >= H_MIN) && (img_h <= H_LIM);
  assign w_row_last = ({1'b0, r_row} == (r_h - HD'(1)));
  assign w_more = (({1'b0, r_col} + W_NEXT) <= r_w);

  // Push k of a strip closes the window of rows k-3..k-1; the
  // flush is push img_h and always carries the strip's last result.
  assign w_img_issue = r_rd_en & ~r_sel;
  assign w_flush = (r_state == S_FLUSH);
  assign w_qual = (w_img_issue & (r_row >= K_ROW)) | w_flush;
  assign w_tag_row = w_flush ? (r_row - K_LAST) : (r_row - K_ROW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_w     <= '0;
      r_h     <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rd_en <= 1'b0;
      r_sel   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_w   <= img_w;
            r_h   <= img_h;
            r_row <= '0;
            r_col <= '0;
            if (w_dims_ok) begin
              r_state <= S_LOAD_K;
              r_busy  <= 1'b1;
              r_rd_en <= 1'b1;
              r_sel   <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end
          end
        end
        S_LOAD_K: begin
          if (r_row == K_LAST) begin
            r_state <= S_STREAM;
            r_sel   <= 1'b0;
            r_row   <= '0;
          end else begin
            r_row <= r_row + 1'b1;
          end
        end
        S_STREAM: begin
          if (w_row_last) begin
            r_state <= S_FLUSH;
            r_rd_en <= 1'b0;
          end else begin
            r_row <= r_row + 1'b1;
          end
        end
        S_FLUSH: begin
          if (w_more) begin
            r_state <= S_STREAM;
            r_rd_en <= 1'b1;
            r_row   <= '0;
            r_col   <= r_col + 1'b1;
          end else begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!r_p_tag && !r_t1_v) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vin    <= 1'b0;
      r_kld    <= 1'b0;
      r_zero   <= 1'b0;
      r_p_tag  <= 1'b0;
      r_p_row  <= '0;
      r_p_col  <= '0;
      r_t1_v   <= 1'b0;
      r_t1_row <= '0;
      r_t1_col <= '0;
      r_t2_v   <= 1'b0;
      r_t2_row <= '0;
      r_t2_col <= '0;
    end else begin
      r_vin    <= r_rd_en | w_flush;
      r_kld    <= r_rd_en & r_sel;
      r_zero   <= w_flush;
      r_p_tag  <= w_qual;
      r_p_row  <= w_qual ? w_tag_row : '0;
      r_p_col  <= w_qual ? r_col : '0;
      r_t1_v   <= r_p_tag;
      r_t1_row <= r_p_row;
      r_t1_col <= r_p_col;
      r_t2_v   <= r_t1_v;
      r_t2_row <= r_t1_row;
      r_t2_col <= r_t1_col;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign mem_rd_en = r_rd_en;
  assign mem_sel   = r_sel;
  assign mem_row   = r_row;
  assign mem_col   = r_col;

  assign conv_data_in     = (r_vin & ~r_zero) ? mem_rd_data : '0;
  assign conv_valid_in    = r_vin;
  assign conv_kernel_load = r_kld;
  assign conv_valid_out   = r_t1_v;

  assign out_valid = r_t2_v;
  assign out_row   = r_t2_row;
  assign out_col   = r_t2_col;
  assign out_data  = conv_result;

endmodule

// File: tb/tb_conv_3_sched.sv
// tb_conv_3_sched: directed and random runs of the strip scheduler,
// with a behavioural memory and datapath, against a direct convolution.
module tb_conv_3_sched;
  localparam int MAXD  = 64;
  localparam int LIMIT = 20000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  img_w;
  logic [6:0]  img_h;
  logic        busy;
  logic        done;
  logic        err;
  logic        mem_rd_en;
  logic        mem_sel;
  logic [5:0]  mem_row;
  logic [5:0]  mem_col;
  logic [47:0] mem_rd_data;
  logic [47:0] conv_data_in;
  logic        conv_kernel_load;
  logic        conv_valid_in;
  logic        conv_valid_out;
  logic [15:0] conv_result;
  logic        out_valid;
  logic [5:0]  out_row;
  logic [5:0]  out_col;
  logic [15:0] out_data;

  int img[MAXD][MAXD+2];
  int kern[3][3];
  int kw[3][3];
  int win[3][3];
  int acc;
  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] fd;

  conv_3_sched dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .img_w            (img_w),
    .img_h            (img_h),
    .busy             (busy),
    .done             (done),
    .err              (err),
    .mem_rd_en        (mem_rd_en),
    .mem_sel          (mem_sel),
    .mem_row          (mem_row),
    .mem_col          (mem_col),
    .mem_rd_data      (mem_rd_data),
    .conv_data_in     (conv_data_in),
    .conv_kernel_load (conv_kernel_load),
    .conv_valid_in    (conv_valid_in),
    .conv_valid_out   (conv_valid_out),
    .conv_result      (conv_result),
    .out_valid        (out_valid),
    .out_row          (out_row),
    .out_col          (out_col),
    .out_data         (out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] int2h(int n);
    int e;
    logic [15:0] m;
    if (n == 0) return 16'h0;
    e = 0;
    for (int b = 0; b < 11; b++) if (n >= (1 << b)) e = b;
    m = 16'((n << (10 - e)) & 32'h3FF);
    return 16'((e + 15) << 10) | m;
  endfunction

  function automatic int h2int(logic [15:0] h);
    int e;
    int m;
    if (h == 16'h0) return 0;
    e = int'(h[14:10]) - 15;
    m = int'({1'b1, h[9:0]});
    return m >> (10 - e);
  endfunction

  function automatic int wsum();
    int s;
    s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) s += win[i][j] * kw[i][j];
    return s;
  endfunction

  function automatic int ref_conv(int r, int c);
    int s;
    s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) s += kern[i][j] * img[r+i][c+j];
    return s;
  endfunction

  function automatic logic outs_or();
    return |{busy, done, err, mem_rd_en, mem_sel, mem_row, mem_col,
             conv_data_in, conv_kernel_load, conv_valid_in,
             conv_valid_out, out_valid, out_row, out_col, out_data};
  endfunction

  // Memory: 1-cycle read latency, three adjacent FP16 lanes.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      for (int j = 0; j < 3; j++) begin
        int ri;
        int ci;
        ri = int'(mem_row);
        ci = int'(mem_col) + j;
        if (mem_sel)
          mem_rd_data[j*16 +: 16] <= (ri < 3) ? int2h(kern[ri][j]) : 16'h0;
        else
          mem_rd_data[j*16 +: 16] <= int2h(img[ri][ci]);
      end
    end
  end

  // Datapath: latch pre-shift window sum on image pushes, emit on valid_out.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          kw[i][j]  <= 0;
          win[i][j] <= 0;
        end
      acc <= 0;
      conv_result <= 16'h0;
    end else begin
      if (conv_valid_out) conv_result <= int2h(acc);
      if (conv_valid_in && conv_kernel_load) begin
        for (int j = 0; j < 3; j++) begin
          kw[0][j] <= kw[1][j];
          kw[1][j] <= kw[2][j];
          kw[2][j] <= h2int(conv_data_in[j*16 +: 16]);
        end
      end else if (conv_valid_in) begin
        acc <= wsum();
        for (int j = 0; j < 3; j++) begin
          win[0][j] <= win[1][j];
          win[1][j] <= win[2][j];
          win[2][j] <= h2int(conv_data_in[j*16 +: 16]);
        end
      end
    end
  end

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill(int pat);
    for (int r = 0; r < MAXD; r++)
      for (int c = 0; c < MAXD + 2; c++)
        img[r][c] = (pat == 0) ? int'($urandom_range(7, 0)) :
                    (pat == 1) ? 1 : r;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        kern[i][j] = (pat == 0) ? int'($urandom_range(3, 0)) :
                     (pat == 1) ? 1 : ((i == 1 && j == 1) ? 1 : 0);
  endtask

  // mode 0: plain run, 1: extra start pulses mid-run, 2: reset mid-run
  task automatic run_case(string nm, int w, int h, int mode,
                          output logic [15:0] first_dat);
    int cy, done_cy, exp_done, n_push, n_rd, n_kld, n_busy, n_stray;
    int n_exp, b_pos, b_dat, b_cy;
    logic err_at;
    bit ok;
    int q_row[$];
    int q_col[$];
    int q_dat[$];
    int q_cy[$];
    ok = (w >= 3 && w <= MAXD && h >= 3 && h <= MAXD);
    first_dat = 16'h0;
    img_w = 7'(w);
    img_h = 7'(h);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    img_w = 7'($urandom);
    img_h = 7'($urandom);
    cy = 1;
    done_cy = -1;
    n_push = 0; n_rd = 0; n_kld = 0; n_busy = 0; n_stray = 0;
    err_at = 1'b0;
    while (cy < LIMIT) begin
      if (mode == 2 && cy == 13) begin
        rst = 1'b1;
        #1;
        chk({nm, "/rst_now"}, outs_or(), 0);
        @(negedge clk);
        chk({nm, "/rst_next"}, outs_or(), 0);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (out_valid || done || busy || mem_rd_en) n_stray++;
        end
        chk({nm, "/post_rst_quiet"}, n_stray, 0);
        return;
      end
      start = (mode == 1) && (cy == 6 || cy == 15);
      if (out_valid) begin
        q_row.push_back(int'(out_row));
        q_col.push_back(int'(out_col));
        q_dat.push_back(int'(out_data));
        q_cy.push_back(cy);
      end
      if (conv_valid_in) n_push++;
      if (conv_kernel_load) n_kld++;
      if (mem_rd_en) n_rd++;
      if (busy) n_busy++;
      if (err && !done) n_stray++;
      if (done) begin
        done_cy = cy;
        err_at = err;
        break;
      end
      @(negedge clk);
      cy++;
    end
    start = 1'b0;
    chk({nm, "/done_seen"}, done_cy >= 0, 1);
    @(negedge clk);
    chk({nm, "/done_pulse"}, {done, busy, err}, 0);
    chk({nm, "/err_stray"}, n_stray, 0);
    chk({nm, "/err"}, err_at, !ok);
    n_exp = ok ? (w - 2) * (h - 2) : 0;
    chk({nm, "/count"}, q_row.size(), n_exp);
    if (!ok) begin
      chk({nm, "/done_cy"}, done_cy, 1);
      chk({nm, "/reads"}, n_rd, 0);
      chk({nm, "/busy"}, n_busy, 0);
    end else begin
      exp_done = 11 + (w - 3) * (h + 1) + (h - 3);
      chk({nm, "/pushes"}, n_push, 3 + (w - 2) * (h + 1));
      chk({nm, "/reads"}, n_rd, 3 + (w - 2) * h);
      chk({nm, "/kloads"}, n_kld, 3);
      chk({nm, "/done_cy"}, done_cy, exp_done);
      chk({nm, "/busy"}, n_busy, exp_done - 1);
      b_pos = 0; b_dat = 0; b_cy = 0;
      for (int i = 0; i < n_exp && i < q_row.size(); i++) begin
        int cc;
        int rr;
        cc = i / (h - 2);
        rr = i % (h - 2);
        if (q_row[i] != rr || q_col[i] != cc) b_pos++;
        if (q_dat[i] != int'(int2h(ref_conv(rr, cc)))) b_dat++;
        if (q_cy[i] != 10 + cc * (h + 1) + rr) b_cy++;
      end
      chk({nm, "/bad_tags"}, b_pos, 0);
      chk({nm, "/bad_data"}, b_dat, 0);
      chk({nm, "/bad_timing"}, b_cy, 0);
      if (q_row.size() > 0) begin
        chk({nm, "/last_row"}, q_row[$], h - 3);
        chk({nm, "/last_col"}, q_col[$], w - 3);
        chk({nm, "/done_after_last"}, done_cy - q_cy[$], 1);
        first_dat = 16'(q_dat[0]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    img_w = '0;
    img_h = '0;
    fill(0);
    repeat (3) @(negedge clk);
    chk("reset_outs", outs_or(), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", outs_or(), 0);

    fill(1);
    run_case("min3x3", 3, 3, 0, fd);
    chk("min3x3/data", fd, 16'h4880);
    fill(2);
    run_case("r4x5", 4, 5, 0, fd);
    chk("r4x5/first", fd, 16'h3C00);
    fill(0);
    run_case("bad_w2", 2, 5, 0, fd);
    run_case("bad_h65", 5, 65, 0, fd);
    fill(0);
    run_case("busy_start", 5, 6, 1, fd);
    fill(0);
    run_case("rst_mid", 6, 6, 2, fd);
    run_case("after_rst", 6, 6, 0, fd);
    for (int n = 0; n < 6; n++) begin
      fill(0);
      run_case($sformatf("rnd%0d", n), int'($urandom_range(12, 3)),
               int'($urandom_range(12, 3)), 0, fd);
    end
    fill(0);
    run_case("max", MAXD, MAXD, 0, fd);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
